regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_pkg.sv | 41 ++++
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the result-entry struct and the hold-register update rule.
package regfile_wb_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RW       = 5;
  localparam int NREG     = 32;
  localparam int SW       = 4;

  localparam logic [RW-1:0] X0 = 5'd0;

  typedef struct packed {
    logic                valid;
    logic [RW-1:0]       rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

  // Flush beats a new transfer, which beats draining.
  function automatic wb_entry_t hold_next(
    input wb_entry_t           q,
    input logic                flush,
    input logic                xfer,
    input logic                gnt,
    input logic [RW-1:0]       rd,
    input logic [XLEN_DEF-1:0] data
  );
    wb_entry_t n;
    n = q;
    if (flush) begin
      n.valid = 1'b0;
    end else if (xfer) begin
      n.valid = 1'b1;
      n.rd    = rd;
      n.data  = data;
    end else if (gnt) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Result channels, issue port and register-file write port
// of the write-back arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            i_flush;
  logic            i_ex_valid;
  logic            o_ex_ready;
  logic [RW-1:0]   i_ex_rd;
  logic [XLEN-1:0] i_ex_data;
  logic            i_ld_valid;
  logic            o_ld_ready;
  logic [RW-1:0]   i_ld_rd;
  logic [XLEN-1:0] i_ld_data;
  logic            i_issue_valid;
  logic [RW-1:0]   i_issue_rd;
  logic [RW-1:0]   o_waddr;
  logic [XLEN-1:0] o_wdata;
  logic [NREG-1:0] o_busy;

  modport master (
    output i_flush,
    output i_ex_valid, i_ex_rd, i_ex_data,
    output i_ld_valid, i_ld_rd, i_ld_data,
    output i_issue_valid, i_issue_rd,
    input  o_ex_ready, o_ld_ready,
    input  o_waddr, o_wdata, o_busy
  );

  modport slave (
    input  i_flush,
    input  i_ex_valid, i_ex_rd, i_ex_data,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    input  i_issue_valid, i_issue_rd,
    output o_ex_ready, o_ld_ready,
    output o_waddr, o_wdata, o_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write flags; set on issue, cleared one edge
// after the write port held the register, set wins over clear.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_set,
  input  logic [RW-1:0]   i_set_rd,
  input  logic [RW-1:0]   i_clr_rd,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (i_clr_rd != X0) busy_d[i_clr_rd] = 1'b0;
    if (i_set && i_set_rd != X0) busy_d[i_set_rd] = 1'b1;
    if (i_flush) busy_d = '0;
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between exec and load results,
// with one hold entry per channel and an exec anti-starvation counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int STARVE_MAX = 3
)(
  input logic                 i_clk,
  input logic                 i_rst_n,
  regfile_wb_arbiter_if.slave bus
);

  wb_entry_t       ex_q, ex_d;
  wb_entry_t       ld_q, ld_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [RW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic starved;
  logic gnt_ex, gnt_ld;
  logic ex_rdy, ld_rdy;
  logic ex_xfer, ld_xfer;

  always_comb begin
    starved = (starve_q == SW'(STARVE_MAX));
    gnt_ex  = ex_q.valid && (!ld_q.valid || starved);
    gnt_ld  = ld_q.valid && !gnt_ex;

    // A hold drained this cycle can refill at the same edge.
    ex_rdy  = i_rst_n && !bus.i_flush
              && (!ex_q.valid || gnt_ex);
    ld_rdy  = i_rst_n && !bus.i_flush
              && (!ld_q.valid || gnt_ld);
    ex_xfer = bus.i_ex_valid && ex_rdy;
    ld_xfer = bus.i_ld_valid && ld_rdy;

    ex_d = hold_next(ex_q, bus.i_flush, ex_xfer,
                     gnt_ex, bus.i_ex_rd, bus.i_ex_data);
    ld_d = hold_next(ld_q, bus.i_flush, ld_xfer,
                     gnt_ld, bus.i_ld_rd, bus.i_ld_data);

    waddr_d = X0;
    wdata_d = '0;
    if (!bus.i_flush && gnt_ex) begin
      waddr_d = ex_q.rd;
      wdata_d = ex_q.data;
    end else if (!bus.i_flush && gnt_ld) begin
      waddr_d = ld_q.rd;
      wdata_d = ld_q.data;
    end

    starve_d = starve_q;
    if (bus.i_flush || !ex_q.valid || gnt_ex) begin
      starve_d = '0;
    end else if (gnt_ld && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q     <= '0;
      ld_q     <= '0;
      starve_q <= '0;
      waddr_q  <= X0;
      wdata_q  <= '0;
    end else begin
      ex_q     <= ex_d;
      ld_q     <= ld_d;
      starve_q <= starve_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  regfile_scoreboard u_sb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (bus.i_flush),
    .i_set    (bus.i_issue_valid),
    .i_set_rd (bus.i_issue_rd),
    .i_clr_rd (waddr_q),
    .o_busy   (bus.o_busy)
  );

  assign bus.o_ex_ready = ex_rdy;
  assign bus.o_ld_ready = ld_rdy;
  assign bus.o_waddr    = waddr_q;
  assign bus.o_wdata    = wdata_q;

endmodule
